// File: rtl/window_3x3_gen_if.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : window_3x3_gen_if                                           |
// | Brief    : Pixel-in / 3x3-window-out bundle for window_3x3_gen.        |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
interface window_3x3_gen_if;
  logic [11:0] pixIn;
  logic        pixValid;
  logic        sof;

  logic [11:0] winLU, winMU, winRU;
  logic [11:0] winLM, winMM, winRM;
  logic [11:0] winLD, winMD, winRD;
  logic        outValid;
  logic [9:0]  outCol;
  logic [8:0]  outRow;

  // master = pixel source / window sink, slave = the window generator
  modport master (
    output pixIn, pixValid, sof,
    input  winLU, winMU, winRU, winLM, winMM, winRM, winLD, winMD, winRD,
    input  outValid, outCol, outRow
  );

  modport slave (
    input  pixIn, pixValid, sof,
    output winLU, winMU, winRU, winLM, winMM, winRM, winLD, winMD, winRD,
    output outValid, outCol, outRow
  );
endinterface
`default_nettype wire

// File: rtl/window_3x3_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : window_3x3_gen                                              |
// | Brief    : Streams RGB444 pixels and emits one zero-padded 3x3 window  |
// |            per accepted pixel, one cycle later, with centre position.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module window_3x3_gen #(
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240
) (
  input  wire logic       readClk,
  input  wire logic       rstN,
  window_3x3_gen_if.slave bus
);

  localparam int         c_ADDR_W   = $clog2(IMG_WIDTH);
  localparam logic [9:0] c_LAST_COL = 10'(IMG_WIDTH - 1);
  localparam logic [8:0] c_LAST_ROW = 9'(IMG_HEIGHT - 1);

  // ---------------- position tracking ----------------
  logic [9:0] r_colCnt;
  logic [8:0] r_rowCnt;
  logic [9:0] w_col, w_colNext;
  logic [8:0] w_row, w_rowNext;
  logic [c_ADDR_W-1:0] w_addr;

  // sof pins the current pixel to the frame origin regardless of count state
  always_comb begin
    w_col     = bus.sof ? 10'd0 : r_colCnt;
    w_row     = bus.sof ? 9'd0  : r_rowCnt;
    w_colNext = w_col + 10'd1;
    w_rowNext = w_row;
    if (w_col == c_LAST_COL) begin
      w_colNext = 10'd0;
      w_rowNext = (w_row == c_LAST_ROW) ? 9'd0 : w_row + 9'd1;
    end
    w_addr = w_col[c_ADDR_W-1:0];
  end

  always_ff @(posedge readClk or negedge rstN) begin
    if (!rstN) begin
      r_colCnt <= 10'd0;
      r_rowCnt <= 9'd0;
    end else if (bus.pixValid) begin
      r_colCnt <= w_colNext;
      r_rowCnt <= w_rowNext;
    end
  end

  // ---------------- line buffers (never reset) ----------------
  logic [11:0] r_lineMid [IMG_WIDTH];
  logic [11:0] r_lineTop [IMG_WIDTH];

  always_ff @(posedge readClk) begin
    if (bus.pixValid) begin
      r_lineMid[w_addr] <= bus.pixIn;
      r_lineTop[w_addr] <= r_lineMid[w_addr];
    end
  end

  // ---------------- stage 1: capture pixel, position and column above ----------------
  logic        r_s1Valid;
  logic [11:0] r_s1Pix, r_s1Mid, r_s1Top;
  logic [9:0]  r_s1Col;
  logic [8:0]  r_s1Row;

  always_ff @(posedge readClk or negedge rstN) begin
    if (!rstN) begin
      r_s1Valid <= 1'b0;
      r_s1Pix   <= 12'h000;
      r_s1Mid   <= 12'h000;
      r_s1Top   <= 12'h000;
      r_s1Col   <= 10'd0;
      r_s1Row   <= 9'd0;
    end else begin
      r_s1Valid <= bus.pixValid;
      if (bus.pixValid) begin
        r_s1Pix <= bus.pixIn;
        r_s1Mid <= r_lineMid[w_addr];
        r_s1Top <= r_lineTop[w_addr];
        r_s1Col <= w_col;
        r_s1Row <= w_row;
      end
    end
  end

  // ---------------- stage 2: column history and edge masking ----------------
  logic [11:0] r_topC1, r_topC2, r_midC1, r_midC2, r_botC1, r_botC2;
  logic        w_topOk, w_midOk, w_leftOk, w_centreOk;
  logic [11:0] w_winLU, w_winMU, w_winRU;
  logic [11:0] w_winLM, w_winMM, w_winRM;
  logic [11:0] w_winLD, w_winMD, w_winRD;
  logic [9:0]  w_outCol;
  logic [8:0]  w_outRow;

  // Masking by position also hides history left over from the previous line
  always_comb begin
    w_topOk    = (r_s1Row >= 9'd2);
    w_midOk    = (r_s1Row >= 9'd1);
    w_leftOk   = (r_s1Col >= 10'd2);
    w_centreOk = (r_s1Col >= 10'd1);

    w_winLU = (w_topOk && w_leftOk)   ? r_topC2 : 12'h000;
    w_winMU = (w_topOk && w_centreOk) ? r_topC1 : 12'h000;
    w_winRU = w_topOk                 ? r_s1Top : 12'h000;
    w_winLM = (w_midOk && w_leftOk)   ? r_midC2 : 12'h000;
    w_winMM = (w_midOk && w_centreOk) ? r_midC1 : 12'h000;
    w_winRM = w_midOk                 ? r_s1Mid : 12'h000;
    w_winLD = w_leftOk                ? r_botC2 : 12'h000;
    w_winMD = w_centreOk              ? r_botC1 : 12'h000;
    w_winRD = r_s1Pix;

    w_outCol = (r_s1Col == 10'd0) ? 10'h3FF : r_s1Col - 10'd1;
    w_outRow = (r_s1Row == 9'd0)  ? 9'h1FF  : r_s1Row - 9'd1;
  end

  logic [11:0] r_winLU, r_winMU, r_winRU;
  logic [11:0] r_winLM, r_winMM, r_winRM;
  logic [11:0] r_winLD, r_winMD, r_winRD;
  logic        r_outValid;
  logic [9:0]  r_outCol;
  logic [8:0]  r_outRow;

  always_ff @(posedge readClk or negedge rstN) begin
    if (!rstN) begin
      r_topC1 <= 12'h000;
      r_topC2 <= 12'h000;
      r_midC1 <= 12'h000;
      r_midC2 <= 12'h000;
      r_botC1 <= 12'h000;
      r_botC2 <= 12'h000;
      r_winLU <= 12'h000;
      r_winMU <= 12'h000;
      r_winRU <= 12'h000;
      r_winLM <= 12'h000;
      r_winMM <= 12'h000;
      r_winRM <= 12'h000;
      r_winLD <= 12'h000;
      r_winMD <= 12'h000;
      r_winRD <= 12'h000;
      r_outCol <= 10'd0;
      r_outRow <= 9'd0;
    end else if (r_s1Valid) begin
      r_topC2 <= r_topC1;
      r_topC1 <= r_s1Top;
      r_midC2 <= r_midC1;
      r_midC1 <= r_s1Mid;
      r_botC2 <= r_botC1;
      r_botC1 <= r_s1Pix;
      r_winLU <= w_winLU;
      r_winMU <= w_winMU;
      r_winRU <= w_winRU;
      r_winLM <= w_winLM;
      r_winMM <= w_winMM;
      r_winRM <= w_winRM;
      r_winLD <= w_winLD;
      r_winMD <= w_winMD;
      r_winRD <= w_winRD;
      r_outCol <= w_outCol;
      r_outRow <= w_outRow;
    end
  end

  always_ff @(posedge readClk or negedge rstN) begin
    if (!rstN) begin
      r_outValid <= 1'b0;
    end else begin
      r_outValid <= r_s1Valid;
    end
  end

  assign bus.winLU    = r_winLU;
  assign bus.winMU    = r_winMU;
  assign bus.winRU    = r_winRU;
  assign bus.winLM    = r_winLM;
  assign bus.winMM    = r_winMM;
  assign bus.winRM    = r_winRM;
  assign bus.winLD    = r_winLD;
  assign bus.winMD    = r_winMD;
  assign bus.winRD    = r_winRD;
  assign bus.outValid = r_outValid;
  assign bus.outCol   = r_outCol;
  assign bus.outRow   = r_outRow;

endmodule
`default_nettype wire

// File: tb/tb_window_3x3_gen.sv
`timescale 1ns/1ps
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_window_3x3_gen                                           |
// | Brief    : Randomised bench for window_3x3_gen against an image model. |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_window_3x3_gen;
  localparam int W = 320;
  localparam int H = 16;

  logic readClk = 1'b0;
  logic rstN    = 1'b1;

  window_3x3_gen_if bus ();

  window_3x3_gen #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .readClk (readClk),
    .rstN    (rstN),
    .bus     (bus)
  );

  always #5 readClk = ~readClk;

  // {valid, row, col, LU, MU, RU, LM, MM, RM, LD, MD, RD}
  logic [127:0] obsVec;
  assign obsVec = {bus.outValid, bus.outRow, bus.outCol,
                   bus.winLU, bus.winMU, bus.winRU,
                   bus.winLM, bus.winMM, bus.winRM,
                   bus.winLD, bus.winMD, bus.winRD};

  // Reference model: whole image stored, window read by coordinates
  logic [11:0]  img [H][W];
  int           mRow, mCol;
  logic [127:0] lastWin, pending;
  int           errors = 0;
  int           checks = 0;

  function automatic logic [11:0] tap(input int r, input int c);
    if (r < 0 || c < 0) return 12'h000;
    return img[r][c];
  endfunction

  task automatic modelStep(input logic [11:0] p, input logic v, input logic s,
                           output logic [127:0] e);
    if (!v) begin
      e = {1'b0, lastWin[126:0]};
      return;
    end
    if (s) begin
      mRow = 0;
      mCol = 0;
    end
    img[mRow][mCol] = p;
    e = {1'b1,
         (mRow == 0) ? 9'h1FF  : 9'(mRow - 1),
         (mCol == 0) ? 10'h3FF : 10'(mCol - 1),
         tap(mRow - 2, mCol - 2), tap(mRow - 2, mCol - 1), tap(mRow - 2, mCol),
         tap(mRow - 1, mCol - 2), tap(mRow - 1, mCol - 1), tap(mRow - 1, mCol),
         tap(mRow,     mCol - 2), tap(mRow,     mCol - 1), p};
    lastWin = e;
    mCol++;
    if (mCol == W) begin
      mCol = 0;
      mRow++;
      if (mRow == H) mRow = 0;
    end
  endtask

  // Drives one cycle; returns what the outputs show after the edge and what
  // they should show (the window of the pixel from the previous cycle).
  task automatic cycle(input logic [11:0] p, input logic v, input logic s,
                       output logic [127:0] got, output logic [127:0] want);
    logic [127:0] e;
    bus.pixIn    = p;
    bus.pixValid = v;
    bus.sof      = s;
    modelStep(p, v, s, e);
    @(posedge readClk);
    #1;
    got     = obsVec;
    want    = pending;
    pending = e;
  endtask

  task automatic modelReset();
    mRow    = 0;
    mCol    = 0;
    lastWin = '0;
    pending = '0;
  endtask

  task automatic doReset();
    bus.pixIn    = 12'h000;
    bus.pixValid = 1'b0;
    bus.sof      = 1'b0;
    rstN         = 1'b0;
    repeat (2) @(posedge readClk);
    #1;
    rstN = 1'b1;
    modelReset();
  endtask

  task automatic test_reset();
    logic [127:0] got, want;
    bus.pixIn    = 12'h000;
    bus.pixValid = 1'b0;
    bus.sof      = 1'b0;
    #2 rstN = 1'b0;
    #1;
    checks++;
    if (obsVec !== 128'h0) begin
      errors++;
      $display("FAIL reset_state: got=%h want=%h", obsVec, 128'h0);
    end
    repeat (2) @(posedge readClk);
    #1;
    rstN = 1'b1;
    modelReset();
    cycle(12'h000, 1'b0, 1'b1, got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL reset_idle: got=%h want=%h", got, want);
    end
  endtask

  task automatic test_first_pixel();
    logic [127:0] got, want;
    doReset();
    cycle(12'hABC, 1'b1, 1'b1, got, want);
    cycle(12'h000, 1'b0, 1'b0, got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL first_pixel_model: got=%h want=%h", got, want);
    end
    checks++;
    if (got !== {1'b1, 9'h1FF, 10'h3FF, 96'h0, 12'hABC}) begin
      errors++;
      $display("FAIL first_pixel_const: got=%h want=%h", got,
               {1'b1, 9'h1FF, 10'h3FF, 96'h0, 12'hABC});
    end
  endtask

  task automatic test_frame();
    logic [127:0] got, want;
    int prevR, prevC;
    logic [11:0] p;
    doReset();
    prevR = -1;
    prevC = -1;
    for (int r = 0; r < H + 2; r++) begin
      for (int c = 0; c < W; c++) begin
        p = {4'(r % H), 4'(c), 4'h5};
        cycle(p, 1'b1, (r == H && c == 0), got, want);
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL frame_window r=%0d c=%0d: got=%h want=%h", prevR, prevC, got, want);
        end
        if (prevR == 5 && prevC == 7) begin
          checks++;
          if (got[107:96] !== 12'h355 || got[59:48] !== 12'h465 || got[11:0] !== 12'h575 ||
              got[126:118] !== 9'd4 || got[117:108] !== 10'd6) begin
            errors++;
            $display("FAIL frame_point_5_7: got=%h want LU=355 MM=465 RD=575 row=4 col=6", got);
          end
        end
        if (prevR == 2 && prevC == 0) begin
          checks++;
          if (got[83:72] !== 12'h005 || got[47:36] !== 12'h105 || got[11:0] !== 12'h205 ||
              got[107:84] !== 24'h0 || got[71:48] !== 24'h0 || got[35:12] !== 24'h0) begin
            errors++;
            $display("FAIL frame_point_2_0: got=%h want RU=005 RM=105 RD=205 L/M=0", got);
          end
        end
        prevR = r % H;
        prevC = c;
      end
    end
    cycle(12'h000, 1'b0, 1'b0, got, want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL frame_flush: got=%h want=%h", got, want);
    end
  endtask

  task automatic test_gaps();
    logic [127:0] got, want;
    logic [127:0] refQ[$];
    logic [11:0]  px[3*W];
    int k, idx;
    for (int i = 0; i < 3 * W; i++) px[i] = 12'($urandom);
    doReset();
    for (int i = 0; i <= 3 * W; i++) begin
      if (i < 3 * W) cycle(px[i], 1'b1, (i == 0), got, want);
      else           cycle(12'h000, 1'b0, 1'b0, got, want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL gapless_window i=%0d: got=%h want=%h", i, got, want);
      end
      if (got[127]) refQ.push_back(got);
    end
    doReset();
    k = 0;
    idx = 0;
    while (idx < 3 * W || k % 3 != 0) begin
      if (k % 3 == 2 || idx >= 3 * W)
        cycle(12'($urandom), 1'b0, 1'($urandom), got, want);
      else begin
        cycle(px[idx], 1'b1, (idx == 0), got, want);
        idx++;
      end
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL gap_window k=%0d: got=%h want=%h", k, got, want);
      end
      if (got[127]) begin
        checks++;
        if (refQ.size() == 0 || got !== refQ[0]) begin
          errors++;
          $display("FAIL gap_vs_gapless k=%0d: got=%h want=%h", k, got,
                   (refQ.size() == 0) ? 128'h0 : refQ[0]);
        end
        if (refQ.size() != 0) void'(refQ.pop_front());
      end
      k++;
    end
    cycle(12'h000, 1'b0, 1'b0, got, want);
    checks++;
    if (got !== want || refQ.size() != 0) begin
      errors++;
      $display("FAIL gap_tail: got=%h want=%h left=%0d", got, want, refQ.size());
    end
  endtask

  task automatic test_sof_mid();
    logic [127:0] got, want;
    logic [11:0] p, pSof;
    doReset();
    pSof = 12'h000;
    for (int i = 0; i <= 1000 + W + 10; i++) begin
      p = 12'($urandom);
      if (i == 1000) pSof = p;
      cycle(p, 1'b1, (i == 0 || i == 1000), got, want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL sof_window i=%0d: got=%h want=%h", i, got, want);
      end
      if (i == 1001) begin
        checks++;
        if (got !== {1'b1, 9'h1FF, 10'h3FF, 96'h0, pSof}) begin
          errors++;
          $display("FAIL sof_origin: got=%h want=%h", got, {1'b1, 9'h1FF, 10'h3FF, 96'h0, pSof});
        end
      end
      if (i == 1002) begin
        checks++;
        if (got[126:108] !== {9'h1FF, 10'd0} || got[23:12] !== pSof || got[107:60] !== 48'h0) begin
          errors++;
          $display("FAIL sof_next: got=%h want row=1ff col=0 MD=%h", got, pSof);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] got, want;
    logic [11:0] p;
    doReset();
    for (int i = 0; i <= 10 * W + 150; i++)
      cycle(12'($urandom), 1'b1, (i == 0), got, want);
    bus.pixValid = 1'b0;
    #1 rstN = 1'b0;
    #1;
    checks++;
    if (obsVec !== 128'h0) begin
      errors++;
      $display("FAIL reset_mid_async: got=%h want=%h", obsVec, 128'h0);
    end
    @(posedge readClk);
    #1;
    rstN = 1'b1;
    modelReset();
    for (int i = 0; i < W + 5; i++) begin
      p = 12'($urandom);
      cycle(p, 1'b1, 1'b0, got, want);
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid_window i=%0d: got=%h want=%h", i, got, want);
      end
      if (i == 1) begin
        checks++;
        if (got[126:108] !== {9'h1FF, 10'h3FF} || got[107:12] !== 96'h0) begin
          errors++;
          $display("FAIL reset_mid_origin: got=%h want row=1ff col=3ff taps=0", got);
        end
      end
    end
  endtask

  initial begin
    bus.pixIn    = 12'h000;
    bus.pixValid = 1'b0;
    bus.sof      = 1'b0;
    modelReset();
    test_reset();
    test_first_pixel();
    test_frame();
    test_gaps();
    test_sof_mid();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/window_3x3_gen.md
WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 Parameter IMG_WIDTH, default 320, pixels per line (>=3, <=1024).
REQ-002 Parameter IMG_HEIGHT, default 240, lines per frame (>=3, <=512).
REQ-003 readClk  in  1  sole clock; all state on rising edge.
REQ-004 rstN  in  1  reset, asynchronous assert, active-low.
REQ-005 pixIn  in  12  RGB444 pixel {R[11:8],G[7:4],B[3:0]}.
REQ-006 pixValid  in  1  pixIn valid this cycle; no backpressure.
REQ-007 sof  in  1  start of frame; marks the pixel at (row 0, col 0); meaningful only with pixValid.
REQ-008 winLU, winMU, winRU  out  12 each  window top row (rows r-2), columns c-2, c-1, c.
REQ-009 winLM, winMM, winRM  out  12 each  window middle row (r-1), columns c-2, c-1, c.
REQ-010 winLD, winMD, winRD  out  12 each  window bottom row (r), columns c-2, c-1, c.
REQ-011 outValid  out  1  window outputs valid.
REQ-012 outCol  out  10  column of window centre (c-1, two's-wrap not used; see REQ-021).
REQ-013 outRow  out  9  row of window centre (r-1).

Function
REQ-014 One window SHALL be produced per accepted pixel; (r,c) = position of that pixel; winRD = that pixel.
REQ-015 Latency SHALL be exactly 1 cycle: pixel accepted at edge N -> outValid=1 and window after edge N+1; outValid=0 in cycles with no accepted pixel; outputs hold previous values when outValid=0.
REQ-016 Position counters colCnt (0..IMG_WIDTH-1), rowCnt (0..IMG_HEIGHT-1) SHALL advance per accepted pixel: col wraps to 0 and row increments at col=IMG_WIDTH-1; row wraps to 0 after last pixel of frame.
REQ-017 sof with pixValid SHALL force that pixel to (0,0) regardless of counter state; counters continue from (0,1).
REQ-018 sof without pixValid SHALL be ignored.
REQ-019 Two line buffers of IMG_WIDTH x 12 bits SHALL hold rows r-1 and r-2; per accepted pixel, read both at address c, write pixIn to row r-1 buffer and old row r-1 value to row r-2 buffer at address c (read-before-write).
REQ-020 A 3-column shift register per window row SHALL supply columns c-2, c-1; shifting only on accepted pixels.
REQ-021 Taps outside the image SHALL output 12'h000: U taps when r<2, M taps when r<1, L taps when c<2, M-column taps when c<1; no carry-over of previous-line pixels into left columns.
REQ-022 outCol/outRow SHALL equal c-1/r-1; when c=0 or r=0 the corresponding field SHALL be all-ones (IMG edge marker) and the window remains valid.
REQ-023 Line buffer contents SHALL NOT be relied on after reset; REQ-021 zeroing covers all uninitialised reads in the first two rows.
REQ-024 Pixels arriving with gaps (pixValid low) SHALL produce identical windows to a gapless stream.
REQ-025 Downstream consumer accepts every window; block has no stall path.

Reset
REQ-026 rstN low SHALL asynchronously clear colCnt, rowCnt, all shift registers, all window outputs to 12'h000, outValid to 0, outCol/outRow to 0.
REQ-027 Reset mid-frame SHALL abandon the frame; first accepted pixel after release is (0,0) even without sof.
REQ-028 Line buffer RAM SHALL NOT be reset.

Verification
REQ-029 Reset, then 320x240 frame, pixIn = {row[3:0],col[3:0],4'h5} -> at (r=5,c=7): winLU=12'h355, winMM=12'h465, winRD=12'h575, outRow=4, outCol=6, one cycle after input.
REQ-030 First pixel of frame (0,0) = 12'hABC -> winRD=12'hABC, all other 8 taps 12'h000, outRow=outCol=all-ones.
REQ-031 Pixel at (2,0) -> winRU=pixel(0,0), winRM=pixel(1,0), L and M columns all 12'h000.
REQ-032 Same frame with pixValid deasserted every 3rd cycle -> window sequence identical to gapless run; outValid=0 in idle cycles.
REQ-033 sof asserted at pixel index 1000 of a frame -> that pixel reported as (0,0) window (REQ-030 zeroing); next pixel at (0,1).
REQ-034 rstN pulsed low at (100,150) -> outputs zero immediately, outValid=0; next pixel treated as (0,0).
